// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state encoding and counter sizing helpers for the button debouncer
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_w(input int a, input int b);
        return $clog2(max2(a, b));
    endfunction

endpackage

// File: rtl/btn_in_rpt_if.sv
// btn_in_rpt_if: raw button pins in, debounced strobes and levels out
interface btn_in_rpt_if #(parameter int N_BTN = 2);
    logic [N_BTN-1:0] nBIN;
    logic [N_BTN-1:0] BOUT;
    logic [N_BTN-1:0] BREL;
    logic [N_BTN-1:0] BLONG;
    logic [N_BTN-1:0] BLVL;
    modport master (output nBIN, input BOUT, BREL, BLONG, BLVL);
    modport slave  (input nBIN, output BOUT, BREL, BLONG, BLVL);
endinterface

// File: rtl/btn_rpt_ch.sv
// btn_rpt_ch: one debounced button channel with press/release/long/repeat strobes
module btn_rpt_ch
    import btn_pkg::*;
#(
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 4,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic tick_i,
    input  logic p_i,
    output logic bout_o,
    output logic brel_o,
    output logic blong_o,
    output logic blvl_o
);
    localparam int RW = cnt_w(REPEAT_DELAY, REPEAT_RATE);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic          s1_q, s0_q;
    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          bout_q, brel_q, blong_q;
    logic          bout_d, brel_d, blong_d;

    // Edge detection and hold/repeat FSM, evaluated on the pre-update samples of a tick
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        bout_d  = 1'b0;
        blong_d = 1'b0;
        brel_d  = tick_i & ~s1_q & s0_q;
        if (tick_i) begin
            case (state_q)
                IDLE: if (s1_q & ~s0_q) begin
                    state_d = HOLD;
                    rcnt_d  = '0;
                    bout_d  = 1'b1;
                end
                HOLD, REPEAT: if (!s1_q) begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == ((state_q == HOLD) ? DLY_LAST : RATE_LAST)) begin
                    state_d = REPEAT;
                    rcnt_d  = '0;
                    blong_d = (state_q == HOLD);
                    bout_d  = REPEAT_EN;
                end else begin
                    rcnt_d  = rcnt_q + RW'(1);
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    // Two-stage tick sampler, FSM state and one-cycle output strobes
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q    <= 1'b0;
            s0_q    <= 1'b0;
            state_q <= IDLE;
            rcnt_q  <= '0;
            bout_q  <= 1'b0;
            brel_q  <= 1'b0;
            blong_q <= 1'b0;
        end else begin
            if (tick_i) begin
                s1_q <= p_i;
                s0_q <= s1_q;
            end
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            bout_q  <= bout_d;
            brel_q  <= brel_d;
            blong_q <= blong_d;
        end
    end

    assign bout_o  = bout_q;
    assign brel_o  = brel_q;
    assign blong_o = blong_q;
    assign blvl_o  = s0_q;

endmodule

// File: rtl/btn_in_rpt.sv
// btn_in_rpt: N-button debouncer sharing one sample tick divider across all channels
module btn_in_rpt
    import btn_pkg::*;
#(
    parameter int N_BTN        = 2,
    parameter int CLK_DIV      = 1250000,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 4,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    btn_in_rpt_if.slave  bus
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0]    cnt_q;
    logic             tick;
    logic [N_BTN-1:0] p;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));
    assign p    = ACTIVE_LOW ? ~bus.nBIN : bus.nBIN;

    // Free-running sample divider, wrapping to zero on the tick cycle
    always_ff @(posedge CLK) begin
        if (RST || tick) cnt_q <= '0;
        else             cnt_q <= cnt_q + CW'(1);
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_rpt_ch #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_EN)
        ) u_ch (
            .CLK     (CLK),
            .RST     (RST),
            .tick_i  (tick),
            .p_i     (p[g]),
            .bout_o  (bus.BOUT[g]),
            .brel_o  (bus.BREL[g]),
            .blong_o (bus.BLONG[g]),
            .blvl_o  (bus.BLVL[g])
        );
    end

endmodule

// File: tb/tb_btn_in_rpt.sv
// tb_btn_in_rpt: directed tick-by-tick vectors against two instances (repeat on and off)
module tb_btn_in_rpt;

    typedef struct {
        logic [1:0] nbin;
        logic       bnc;
        logic [1:0] bout;
        logic [1:0] brel;
        logic [1:0] blong;
        logic [1:0] blvl;
        logic [1:0] bnr;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] nbin = 2'b11;
    int         checks = 0;
    int         failures = 0;
    vec_t       v [39];

    btn_in_rpt_if #(.N_BTN(2)) ia ();
    btn_in_rpt_if #(.N_BTN(2)) ib ();

    assign ia.nBIN = nbin;
    assign ib.nBIN = nbin;

    btn_in_rpt #(
        .N_BTN(2), .CLK_DIV(4), .ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(3), .REPEAT_RATE(2), .REPEAT_EN(1'b1)
    ) dut_a (.CLK(CLK), .RST(RST), .bus(ia));

    btn_in_rpt #(
        .N_BTN(2), .CLK_DIV(4), .ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(3), .REPEAT_RATE(2), .REPEAT_EN(1'b0)
    ) dut_b (.CLK(CLK), .RST(RST), .bus(ib));

    always #5 CLK = ~CLK;

    function automatic vec_t r(input logic [1:0] n, input logic b, input logic [1:0] bo,
                               input logic [1:0] br, input logic [1:0] bl,
                               input logic [1:0] lv, input logic [1:0] nr);
        vec_t t;
        t.nbin = n; t.bnc = b; t.bout = bo; t.brel = br; t.blong = bl; t.blvl = lv; t.bnr = nr;
        return t;
    endfunction

    function automatic logic [15:0] mk(input logic [1:0] bo, input logic [1:0] br,
                                       input logic [1:0] bl, input logic [1:0] lv,
                                       input logic [1:0] nr);
        return {bo, br, bl, lv, nr, bl, br, lv};
    endfunction

    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] exp);
        logic [15:0] got;
        got = {ia.BOUT, ia.BREL, ia.BLONG, ia.BLVL, ib.BOUT, ib.BLONG, ib.BREL, ib.BLVL};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%b required=%b (a:bout,brel,blong,blvl b:bout,blong,brel,blvl)",
                     nm, idx, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        //          nbin  bnc   bout   brel   blong  blvl   bout(no repeat)
        v[0]  = r(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v[1]  = r(2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v[2]  = r(2'b10, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        v[3]  = r(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        v[4]  = r(2'b11, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        v[5]  = r(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v[6]  = r(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v[7]  = r(2'b01, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10);
        v[8]  = r(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        v[9]  = r(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        v[10] = r(2'b01, 1'b0, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00);
        v[11] = r(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        v[12] = r(2'b01, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
        v[13] = r(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        v[14] = r(2'b01, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
        v[15] = r(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        v[16] = r(2'b11, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
        v[17] = r(2'b11, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
        v[18] = r(2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v[19] = r(2'b10, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        v[20] = r(2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        v[21] = r(2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        v[22] = r(2'b10, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00);
        v[23] = r(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        v[24] = r(2'b11, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        v[25] = r(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v[26] = r(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v[27] = r(2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11);
        v[28] = r(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
        v[29] = r(2'b11, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        v[30] = r(2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v[31] = r(2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v[32] = r(2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v[33] = r(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        v[34] = r(2'b01, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10);
        v[35] = r(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        v[36] = r(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        v[37] = r(2'b01, 1'b0, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00);
        v[38] = r(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);

        RST  = 1'b1;
        nbin = 2'b11;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("reset", i, 16'h0000);
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("pre_tick", i, 16'h0000);
        end

        for (int i = 0; i < 39; i++) begin
            nbin = v[i].nbin;
            edge_step();
            chk("tick", i, mk(v[i].bout, v[i].brel, v[i].blong, v[i].blvl, v[i].bnr));
            for (int j = 0; j < 3; j++) begin
                if (v[i].bnc) nbin[0] = ~nbin[0];
                edge_step();
                chk("gap", i * 4 + j, mk(2'b00, 2'b00, 2'b00, v[i].blvl, 2'b00));
            end
        end

        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            edge_step();
            chk("rst_mid", i, 16'h0000);
        end
        RST = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            edge_step();
            if (k == 8) chk("post_rst", k, mk(2'b10, 2'b00, 2'b00, 2'b10, 2'b10));
            else        chk("post_rst", k, mk(2'b00, 2'b00, 2'b00, (k > 8) ? 2'b10 : 2'b00, 2'b00));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
